// File: rtl/mem_block_fetcher.sv
// Block fetcher: walks a BLK_W x BLK_H window in row-major order on two read
// ports at once (current block on A, reference block on B). It pairs the
// returned words through a 2-entry FIFO and streams them out with valid/ready.
module mem_block_fetcher #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned AWIDTH = 10,
  parameter int unsigned BLK_W  = 4,
  parameter int unsigned BLK_H  = 4,
  parameter int unsigned STRIDE = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [AWIDTH-1:0] cur_base,
  input  logic [AWIDTH-1:0] ref_base,
  output logic [AWIDTH-1:0] address_a,
  output logic [AWIDTH-1:0] address_b,
  output logic              wren_a,
  output logic              wren_b,
  input  logic [DWIDTH-1:0] q_a,
  input  logic [DWIDTH-1:0] q_b,
  output logic [DWIDTH-1:0] pix_cur,
  output logic [DWIDTH-1:0] pix_ref,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CW = (BLK_W > 1) ? $clog2(BLK_W) : 1;
  localparam int unsigned RW = (BLK_H > 1) ? $clog2(BLK_H) : 1;
  localparam logic [CW-1:0] ColMax = CW'(BLK_W - 1);
  localparam logic [RW-1:0] RowMax = RW'(BLK_H - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  state_e state_q;

  logic [AWIDTH-1:0] cur_base_q;
  logic [AWIDTH-1:0] ref_base_q;
  logic [CW-1:0]     col_q;
  logic [CW-1:0]     col_n;
  logic [RW-1:0]     row_q;
  logic [RW-1:0]     row_n;
  logic [AWIDTH-1:0] offset_n;
  logic              at_last_pos;
  logic              issue;
  logic              pop;

  // Read pipeline: pend_q marks that q_a/q_b carry data for a read issued last cycle.
  logic              pend_q;
  logic              pend_last_q;

  // Two-entry pairing FIFO.
  logic [DWIDTH-1:0] fifo_cur_q [2];
  logic [DWIDTH-1:0] fifo_ref_q [2];
  logic [1:0]        fifo_last_q;
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;

  assign wren_a    = 1'b0;
  assign wren_b    = 1'b0;
  assign pix_valid = (count_q != 2'd0);
  assign pix_cur   = fifo_cur_q[rd_ptr_q];
  assign pix_ref   = fifo_ref_q[rd_ptr_q];
  // Gated so a stale tag left in the idle slot never shows up as a last marker.
  assign pix_last  = pix_valid & fifo_last_q[rd_ptr_q];

  // Issue decision and next row/col position for the address walk.
  always_comb begin
    pop         = pix_valid & pix_ready;
    at_last_pos = (col_q == ColMax) && (row_q == RowMax);
    // The address register always presents the next candidate; it counts as issued in this
    // cycle only if buffered entries (less this cycle's pop) plus the word now on q leave room.
    issue = (state_q == StFetch) &&
            (({1'b0, count_q} + {2'b0, pend_q}) < (3'd2 + {2'b0, pop}));
    if (col_q == ColMax) begin
      col_n = '0;
      row_n = row_q + 1'b1;
    end else begin
      col_n = col_q + 1'b1;
      row_n = row_q;
    end
    offset_n = AWIDTH'(32'(row_n) * STRIDE + 32'(col_n));
  end

  // Control FSM with registered addresses, busy and done.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cur_base_q  <= '0;
      ref_base_q  <= '0;
      col_q       <= '0;
      row_q       <= '0;
      address_a   <= '0;
      address_b   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
    end else begin
      pend_q      <= issue;
      pend_last_q <= issue & at_last_pos;
      done        <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            cur_base_q <= cur_base;
            ref_base_q <= ref_base;
            col_q      <= '0;
            row_q      <= '0;
            // Offset zero is presented straight away so the first read goes out next cycle.
            address_a  <= cur_base;
            address_b  <= ref_base;
            busy       <= 1'b1;
            state_q    <= StFetch;
          end
        end
        StFetch: begin
          if (issue) begin
            if (at_last_pos) begin
              // Hold the final address; nothing further is issued.
              state_q <= StDrain;
            end else begin
              col_q     <= col_n;
              row_q     <= row_n;
              address_a <= cur_base_q + offset_n;
              address_b <= ref_base_q + offset_n;
            end
          end
        end
        StDrain: begin
          if (pop && pix_last) begin
            state_q <= StDone;
            done    <= 1'b1;
            busy    <= 1'b0;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Capture returning read data into the FIFO and retire popped entries.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fifo_cur_q[0] <= '0;
      fifo_cur_q[1] <= '0;
      fifo_ref_q[0] <= '0;
      fifo_ref_q[1] <= '0;
      fifo_last_q   <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= '0;
    end else begin
      if (pend_q) begin
        fifo_cur_q[wr_ptr_q]  <= q_a;
        fifo_ref_q[wr_ptr_q]  <= q_b;
        fifo_last_q[wr_ptr_q] <= pend_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, pend_q} - {1'b0, pop};
    end
  end

endmodule
